sram_access_controller: RTL and testbench
=========================================

// Module: sram_access_controller
// PURPOSE
//  Sequences one 32-bit data-memory access onto the external 16-bit asynchronous SRAM as two half-word phases with programmable wait states.
//  Sits between the cache controller's SRAM request port (rd_en/wr_en/address/write_data) and the board SRAM pins.
//  Returns a single-cycle ready pulse per completed 32-bit access.
// PARAMETERS
//  WAIT_CYCLES  5       clk cycles per half-word phase; legal range >=2
//  ADDR_OFFSET  1024    byte base of data memory, subtracted from address
//  SRAM_AW      18      SRAM half-word address width
// PORTS
//  clk         in     1        clock, rising edge
//  rst         in     1        reset, asynchronous, active-high
//  rd_en       in     1        read request, held until ready
//  wr_en       in     1        write request, held until ready
//  address     in     32       byte address; bits [1:0] ignored
//  write_data  in     32       write word
//  read_data   out    32       read word; valid in the ready cycle of a read
//  ready       out    1        access complete, or no request pending
//  sram_dq     inout  16       SRAM data bus
//  sram_addr   out    SRAM_AW  SRAM half-word address
//  sram_we_n   out    1        write strobe, active-low
//  sram_oe_n   out    1        output enable, active-low
//  sram_ce_n   out    1        chip enable, active-low
//  sram_ub_n   out    1        upper byte enable, active-low; tied 0
//  sram_lb_n   out    1        lower byte enable, active-low; tied 0
// BEHAVIOUR
//  States: IDLE, LOW, HIGH, DONE. cnt is a phase counter of width clog2(WAIT_CYCLES).
//  - IDLE: if rd_en|wr_en, latch op, address, write_data; go to LOW with cnt=0.
//  - If rd_en and wr_en are both high in IDLE, the read wins.
//  - LOW/HIGH: cnt increments each cycle. At cnt==WAIT_CYCLES-1: LOW goes to HIGH, HIGH goes to DONE, cnt clears.
//  - DONE: ready=1 for exactly one cycle; next state is IDLE unconditionally.
//  - A request still asserted is re-sampled in IDLE, so back-to-back accesses have a period of 2*WAIT_CYCLES+2 cycles.
//  Address mapping:
//  - wa = (address_latched - ADDR_OFFSET) >> 2. Subtraction is mod 2^32; the result is truncated to SRAM_AW-1 bits.
//  - sram_addr = {wa,1'b0} in LOW and {wa,1'b1} in HIGH; 0 in IDLE/DONE.
//  Write:
//  - sram_dq drives write_data[15:0] in LOW and [31:16] in HIGH; hi-Z otherwise.
//  - sram_we_n=0 for every phase cycle except the last (cnt==WAIT_CYCLES-1), which gives address/data hold.
//  Read:
//  - sram_oe_n=0 throughout LOW/HIGH.
//  - sram_dq is sampled on the last cycle of each phase: LOW into read_data[15:0], HIGH into read_data[31:16].
//  - read_data is registered and holds until the next read capture. Writes do not alter it.
//  Other outputs:
//  - sram_ce_n=0 in LOW/HIGH only.
//  - ready = (state==DONE) | (state==IDLE & ~rd_en & ~wr_en); combinational.
//  Request changes (address, data, enables) after acceptance are ignored until DONE.
//  Reset:
//  - Asynchronous; takes effect mid-access with no completion of the access.
//  - state=IDLE, cnt=0, read_data=0, latched request cleared.
//  - Outputs during and after reset: sram_we_n=1, sram_oe_n=1, sram_ce_n=1, sram_addr=0, sram_dq hi-Z, ready=~(rd_en|wr_en).
// TESTING
//  1. Idle, no request for 20 cycles -> ready=1, sram_ce_n=1, sram_we_n=1, sram_oe_n=1, sram_dq=Z throughout.
//  2. Write address=0x404, data=0xDEADBEEF (W=5):
//     - sram_addr=0x00002, dq=0xBEEF for 5 cycles, we_n low for the first 4.
//     - then sram_addr=0x00003, dq=0xDEAD for 5 cycles.
//     - ready pulses 11 cycles after the accept cycle.
//  3. Read 0x404 from an SRAM model holding test 2's data -> read_data=0xDEADBEEF in the ready cycle; oe_n=0 for all 10 phase cycles.
//  4. rd_en held high, address changed on each ready -> ready pulses exactly 12 cycles apart; each word correct.
//  5. Assert rst during HIGH of a write -> same cycle: we_n=1, ce_n=1, dq=Z, sram_addr=0; after release with no request, ready=1 and state is IDLE.
//  6. Change address/write_data in cycle 3 of an access -> the SRAM sees only the originally latched values.

Source files
------------

// File: rtl/sram_access_controller.sv
// Splits one 32-bit request into two 16-bit asynchronous SRAM phases of WAIT_CYCLES clocks each,
// then pulses ready for one cycle.
module sram_access_controller #(
    parameter int unsigned WAIT_CYCLES = 5,
    parameter int unsigned ADDR_OFFSET = 1024,
    parameter int unsigned SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    inout  wire  [15:0]        sram_dq,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic               sram_we_n,
    output logic               sram_oe_n,
    output logic               sram_ce_n,
    output logic               sram_ub_n,
    output logic               sram_lb_n
);

    localparam int unsigned CNT_W = $clog2(WAIT_CYCLES);
    localparam int unsigned WA_W  = SRAM_AW - 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StLow, StHigh, StDone} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              op_rd_q;
    logic [WA_W-1:0]   wa_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;

    logic [31:0]       addr_diff;
    logic              req;
    logic              in_phase;
    logic              phase_last;
    logic              dq_oe;
    logic [15:0]       dq_out;

    assign req        = rd_en | wr_en;
    assign in_phase   = (state_q == StLow) | (state_q == StHigh);
    assign phase_last = in_phase & (cnt_q == CNT_LAST);
    // Wraps mod 2^32 so addresses below the data-memory base alias to the top of the SRAM.
    assign addr_diff  = address - ADDR_OFFSET;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    state_d = StLow;
                    cnt_d   = '0;
                end
            end
            StLow: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = StHigh;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StHigh: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = StDone;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StDone: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_rd_q <= 1'b0;
            wa_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if ((state_q == StIdle) && req) begin
                op_rd_q <= rd_en;
                wa_q    <= WA_W'(addr_diff >> 2);
                wdata_q <= write_data;
            end
            // SRAM output has had the whole phase to settle by its last cycle.
            if (phase_last && op_rd_q) begin
                if (state_q == StLow) begin
                    rdata_q[15:0] <= sram_dq;
                end else begin
                    rdata_q[31:16] <= sram_dq;
                end
            end
        end
    end

    always_comb begin
        sram_ce_n = ~in_phase;
        sram_oe_n = ~(in_phase & op_rd_q);
        // Strobe released on the last phase cycle to give address/data hold.
        sram_we_n = ~(in_phase & ~op_rd_q & ~phase_last);
        sram_addr = in_phase ? {wa_q, (state_q == StHigh)} : '0;
        dq_oe     = in_phase & ~op_rd_q;
        dq_out    = (state_q == StHigh) ? wdata_q[31:16] : wdata_q[15:0];
        ready     = (state_q == StDone) | ((state_q == StIdle) & ~req);
    end

    assign sram_dq   = dq_oe ? dq_out : 16'hzzzz;
    assign read_data = rdata_q;
    assign sram_ub_n = 1'b0;
    assign sram_lb_n = 1'b0;

endmodule

// File: tb/tb_sram_access_controller.sv
// Bench for sram_access_controller: access-timeline model checked every cycle, SRAM model on the
// bus, and directed accesses with hand-computed expectations.
module tb_sram_access_controller;

    localparam int W   = 5;
    localparam int OFF = 1024;
    localparam int AW  = 18;
    localparam int LAT = 2 * W + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          rd_en, wr_en;
    logic [31:0]   address, write_data, read_data;
    logic          ready;
    wire  [15:0]   sram_dq;
    logic [AW-1:0] sram_addr;
    logic          we_n, oe_n, ce_n, ub_n, lb_n;

    int tests_run = 0;
    int tests_failed = 0;

    sram_access_controller #(.WAIT_CYCLES(W), .ADDR_OFFSET(OFF), .SRAM_AW(AW)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
        .write_data(write_data), .read_data(read_data), .ready(ready), .sram_dq(sram_dq),
        .sram_addr(sram_addr), .sram_we_n(we_n), .sram_oe_n(oe_n), .sram_ce_n(ce_n),
        .sram_ub_n(ub_n), .sram_lb_n(lb_n)
    );

    always #5 clk = ~clk;

    // Asynchronous SRAM: drives when selected and output-enabled, stores while we_n is low.
    logic [15:0] mem [0:(1<<AW)-1];
    assign sram_dq = (!ce_n && !oe_n && we_n) ? mem[sram_addr] : 16'hzzzz;
    always @(posedge clk) if (!ce_n && !we_n) mem[sram_addr] <= sram_dq;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_hiz(input logic [15:0] v);
        return (v === 16'hzzzz) || (v === 16'h0000);
    endfunction

    function automatic logic [16:0] word_of(input logic [31:0] a);
        return 17'((a - 32'(OFF)) / 32'd4);
    endfunction

    // Model: k counts cycles since the accept cycle (0 = idle, 1..W low, W+1..2W high, 2W+1 ready).
    int            k = 0;
    bit            m_rd;
    logic [16:0]   m_wa;
    logic [31:0]   m_wd;
    logic [31:0]   m_hold = 0;
    logic [31:0]   m_mem [int unsigned];
    bit            e_rdy, e_ce, e_oe, e_we, e_drv, hi;
    logic [AW-1:0] e_addr;
    logic [15:0]   e_dq;
    int            j;

    always @(negedge clk) begin
        if (rst) begin
            k      = 0;
            m_hold = 0;
        end
        e_rdy = 0; e_ce = 1; e_oe = 1; e_we = 1; e_addr = '0; e_drv = 0; e_dq = 16'h0;
        if (k == 0) begin
            e_rdy = !(rd_en || wr_en);
        end else if (k <= 2 * W) begin
            hi     = (k > W);
            j      = hi ? k - W - 1 : k - 1;
            e_ce   = 0;
            e_addr = {m_wa, hi};
            if (m_rd) begin
                e_oe = 0;
            end else begin
                e_we  = (j == W - 1);
                e_drv = 1;
                e_dq  = hi ? m_wd[31:16] : m_wd[15:0];
            end
        end else begin
            e_rdy = 1;
            if (m_rd) m_hold = m_mem.exists(m_wa) ? m_mem[m_wa] : 32'h0;
            else m_mem[m_wa] = m_wd;
        end
        check("ctrl{ready,ce_n,oe_n,we_n,addr}", {ready, ce_n, oe_n, we_n, sram_addr},
              {e_rdy, e_ce, e_oe, e_we, e_addr});
        if (k == 0 || k == LAT) check("read_data", read_data, m_hold);
        if (e_drv) check("dq_write", {16'h0, sram_dq}, {16'h0, e_dq});
        else if (e_oe) check("dq_hiz", {31'h0, is_hiz(sram_dq)}, 32'd1);
        if (!rst) begin
            if (k == 0) begin
                if (rd_en || wr_en) begin
                    k    = 1;
                    m_rd = rd_en;
                    m_wa = word_of(address);
                    m_wd = write_data;
                end
            end else if (k == LAT) begin
                k = 0;
            end else begin
                k++;
            end
        end
    end

    logic [AW-1:0] snap_addr [0:40];
    logic [15:0]   snap_dq   [0:40];
    logic          snap_we   [0:40];
    logic          snap_oe   [0:40];
    int            lat;
    logic [31:0]   word;
    realtime       t_prev;

    // Called at posedge+1; cycle 0 is the accept cycle. Leaves the bench at posedge+1 after ready.
    task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                          input bit keep, input int chg_at, input logic [31:0] chg_a,
                          input logic [31:0] chg_d, output int l, output logic [31:0] rw);
        rd_en = rd; wr_en = wr; address = a; write_data = d;
        l = -1;
        rw = 32'h0;
        for (int n = 0; n <= 40; n++) begin
            @(negedge clk);
            snap_addr[n] = sram_addr; snap_dq[n] = sram_dq; snap_we[n] = we_n; snap_oe[n] = oe_n;
            if (ready) begin
                l  = n;
                rw = read_data;
                break;
            end
            if (n == chg_at) begin
                #1;
                address = chg_a; write_data = chg_d;
            end
        end
        if (l < 0) check("ready_timeout", 32'hffffffff, LAT);
        @(posedge clk);
        #1;
        if (!keep) begin
            rd_en = 0; wr_en = 0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1; rd_en = 0; wr_en = 0; address = 0; write_data = 0;
        repeat (3) @(posedge clk);
        #1;
        check("in_reset_ready", {31'h0, ready}, 32'd1);
        rst = 0;
        @(negedge clk);
        check("reset_read_data", read_data, 32'h0);

        repeat (20) @(negedge clk);
        check("idle_ce_we_oe", {29'h0, ce_n, we_n, oe_n}, 32'd7);

        // Write 0x404 <- DEADBEEF.
        @(posedge clk);
        #1;
        access(0, 1, 32'h404, 32'hDEADBEEF, 0, -1, 0, 0, lat, word);
        check("wr_latency", lat, 11);
        check("wr_low_addr", {14'h0, snap_addr[1]}, 32'h2);
        check("wr_low_dq", {16'h0, snap_dq[1]}, 32'hBEEF);
        check("wr_we_first4", {28'h0, snap_we[1], snap_we[2], snap_we[3], snap_we[4]}, 32'h0);
        check("wr_we_hold", {31'h0, snap_we[5]}, 32'd1);
        check("wr_high_addr", {14'h0, snap_addr[6]}, 32'h3);
        check("wr_high_dq", {16'h0, snap_dq[6]}, 32'hDEAD);

        // Read it back; oe_n low for all ten phase cycles.
        access(1, 0, 32'h404, 32'h0, 0, -1, 0, 0, lat, word);
        check("rd_latency", lat, 11);
        check("rd_word", word, 32'hDEADBEEF);
        j = 0;
        for (int n = 1; n <= 10; n++) if (!snap_oe[n]) j++;
        check("rd_oe_cycles", j, 10);

        // Address below the base wraps to the top of the SRAM.
        access(0, 1, 32'h0, 32'h0BADF00D, 0, -1, 0, 0, lat, word);
        check("wrap_low_addr", {14'h0, snap_addr[1]}, 32'h3FE00);
        check("wrap_high_addr", {14'h0, snap_addr[6]}, 32'h3FE01);
        access(1, 0, 32'h3, 32'h0, 0, -1, 0, 0, lat, word);
        check("wrap_rd_word", word, 32'h0BADF00D);

        // Read and write together: read wins, memory untouched.
        access(1, 1, 32'h404, 32'h11111111, 0, -1, 0, 0, lat, word);
        check("rdwr_word", word, 32'hDEADBEEF);
        check("rdwr_no_we", {31'h0, snap_we[1]}, 32'd1);

        // Back-to-back reads with rd_en held.
        access(0, 1, 32'h500, 32'hCAFE0001, 0, -1, 0, 0, lat, word);
        access(0, 1, 32'h504, 32'h12345678, 0, -1, 0, 0, lat, word);
        access(1, 0, 32'h500, 32'h0, 1, -1, 0, 0, lat, word);
        check("b2b_word0", word, 32'hCAFE0001);
        t_prev = $realtime;
        access(1, 0, 32'h504, 32'h0, 1, -1, 0, 0, lat, word);
        check("b2b_word1", word, 32'h12345678);
        check("b2b_period1", int'(($realtime - t_prev) / 10.0), 12);
        t_prev = $realtime;
        access(1, 0, 32'h404, 32'h0, 0, -1, 0, 0, lat, word);
        check("b2b_word2", word, 32'hDEADBEEF);
        check("b2b_period2", int'(($realtime - t_prev) / 10.0), 12);

        // Request changes mid-access are ignored.
        access(0, 1, 32'h40C, 32'hAAAA5555, 0, 2, 32'h800, 32'h0, lat, word);
        check("chg_low_addr", {14'h0, snap_addr[3]}, 32'h6);
        check("chg_low_dq", {16'h0, snap_dq[3]}, 32'h5555);
        check("chg_high_addr", {14'h0, snap_addr[6]}, 32'h7);
        check("chg_high_dq", {16'h0, snap_dq[6]}, 32'hAAAA);
        access(1, 0, 32'h40C, 32'h0, 0, -1, 0, 0, lat, word);
        check("chg_rd_word", word, 32'hAAAA5555);

        // Reset during the high phase of a write.
        rd_en = 0; wr_en = 1; address = 32'h408; write_data = 32'h12345678;
        repeat (7) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1;
        #1;
        check("rst_we_ce_oe", {29'h0, we_n, ce_n, oe_n}, 32'd7);
        check("rst_addr", {14'h0, sram_addr}, 32'h0);
        check("rst_dq_hiz", {31'h0, is_hiz(sram_dq)}, 32'd1);
        check("rst_ready_req", {31'h0, ready}, 32'd0);
        wr_en = 0;
        #1;
        check("rst_ready_noreq", {31'h0, ready}, 32'd1);
        @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        check("post_rst_ready", {31'h0, ready}, 32'd1);
        check("post_rst_read_data", read_data, 32'h0);
        @(posedge clk);
        #1;
        access(1, 0, 32'h404, 32'h0, 0, -1, 0, 0, lat, word);
        check("post_rst_rd_word", word, 32'hDEADBEEF);
        check("post_rst_latency", lat, 11);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
